sgd_rd_scheduler: RTL and testbench

//  Issues the external-memory read requests that feed the A/B dispatch stage of the SGD engine.

---
 rtl/sgd_rd_scheduler_if.sv | 20 ++
 rtl/sgd_rd_scheduler.sv | 162 ++++++++++++++++
 tb/tb_sgd_rd_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sgd_rd_scheduler_if.sv
// Read request/response channel between the SGD read scheduler and external memory.
// The scheduler drives requests; the memory/dispatch side drives the handshakes.
interface sgd_rd_scheduler_if;
  logic [63:0] um_tx_rd_addr;
  logic [7:0]  um_tx_rd_tag;
  logic        um_tx_rd_valid;
  logic        um_tx_rd_ready;
  logic        um_rx_rd_valid;
  logic        um_rx_rd_ready;

  modport master (
    output um_tx_rd_addr, um_tx_rd_tag, um_tx_rd_valid,
    input  um_tx_rd_ready, um_rx_rd_valid, um_rx_rd_ready
  );

  modport slave (
    input  um_tx_rd_addr, um_tx_rd_tag, um_tx_rd_valid,
    output um_tx_rd_ready, um_rx_rd_valid, um_rx_rd_ready
  );
endinterface

// File: rtl/sgd_rd_scheduler.sv
// Issues tagged external-memory reads for the SGD A/B dispatch stage: per batch A_LINES A lines
// then one B line, over all batches and epochs, with a bound on in-flight reads.
module sgd_rd_scheduler #(
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned LINE_BYTES      = 64,
  parameter logic [7:0]  MEM_RD_A_TAG    = 8'h01,
  parameter logic [7:0]  MEM_RD_B_TAG    = 8'h02
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      started,
  input  logic [63:0]               addr_a,
  input  logic [63:0]               addr_b,
  input  logic [31:0]               num_batches,
  input  logic [15:0]               a_lines_per_batch,
  input  logic [31:0]               num_epochs,
  sgd_rd_scheduler_if.master        rd,
  input  logic                      dispatch_almost_full,
  output logic                      sched_done,
  output logic [31:0]               state_counters_sched
);

  typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, DRAIN, DONE} state_t;

  state_t      state_reg, state_next;
  logic        started_r;
  logic [63:0] cfg_addr_a_reg, cfg_addr_b_reg;
  logic [31:0] cfg_batches_reg, cfg_epochs_reg;
  logic [15:0] cfg_a_lines_reg;
  logic [63:0] cur_a_reg, cur_a_next, cur_b_reg, cur_b_next;
  logic [15:0] a_cnt_reg, a_cnt_next;
  logic [31:0] batch_reg, batch_next, epoch_reg, epoch_next;
  logic [7:0]  outstanding_reg;
  logic        valid_reg, valid_next;
  logic        capture, accept, retire, hold, eligible;

  assign capture = (state_reg == IDLE) && started_r;
  assign accept  = valid_reg & rd.um_tx_rd_ready;
  assign retire  = rd.um_rx_rd_valid & rd.um_rx_rd_ready;
  assign hold    = valid_reg & ~rd.um_tx_rd_ready;
  // A presented request counts as in flight so a back-to-back issue cannot overshoot the bound.
  assign eligible = (({1'b0, outstanding_reg} + {8'd0, valid_reg}) < 9'(MAX_OUTSTANDING))
                    && !dispatch_almost_full;

  always_comb begin
    state_next = state_reg;
    cur_a_next = cur_a_reg;
    cur_b_next = cur_b_reg;
    a_cnt_next = a_cnt_reg;
    batch_next = batch_reg;
    epoch_next = epoch_reg;
    valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (started_r) begin
          cur_a_next = addr_a;
          cur_b_next = addr_b;
          a_cnt_next = 16'd0;
          batch_next = 32'd0;
          epoch_next = 32'd0;
          if (num_batches == 32'd0 || a_lines_per_batch == 16'd0 || num_epochs == 32'd0)
            state_next = DONE;
          else
            state_next = ISSUE_A;
        end
      end
      ISSUE_A: begin
        if (accept) begin
          cur_a_next = cur_a_reg + 64'(LINE_BYTES);
          if (a_cnt_reg == cfg_a_lines_reg - 16'd1) begin
            a_cnt_next = 16'd0;
            state_next = ISSUE_B;
          end else begin
            a_cnt_next = a_cnt_reg + 16'd1;
          end
        end
      end
      ISSUE_B: begin
        if (accept) begin
          cur_b_next = cur_b_reg + 64'(LINE_BYTES);
          if (batch_reg == cfg_batches_reg - 32'd1) begin
            batch_next = 32'd0;
            epoch_next = epoch_reg + 32'd1;
            cur_a_next = cfg_addr_a_reg;
            cur_b_next = cfg_addr_b_reg;
            state_next = (epoch_reg == cfg_epochs_reg - 32'd1) ? DRAIN : ISSUE_A;
          end else begin
            batch_next = batch_reg + 32'd1;
            state_next = ISSUE_A;
          end
        end
      end
      DRAIN: begin
        if (outstanding_reg == 8'd0)
          state_next = DONE;
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Valid only rises from inside an issue state, so the first request lags ISSUE_A entry by a cycle.
    if ((state_reg == ISSUE_A || state_reg == ISSUE_B) &&
        (state_next == ISSUE_A || state_next == ISSUE_B))
      valid_next = hold | eligible;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg            <= IDLE;
      started_r            <= 1'b0;
      cur_a_reg            <= 64'd0;
      cur_b_reg            <= 64'd0;
      a_cnt_reg            <= 16'd0;
      batch_reg            <= 32'd0;
      epoch_reg            <= 32'd0;
      valid_reg            <= 1'b0;
      outstanding_reg      <= 8'd0;
      state_counters_sched <= 32'd0;
    end else begin
      state_reg <= state_next;
      cur_a_reg <= cur_a_next;
      cur_b_reg <= cur_b_next;
      a_cnt_reg <= a_cnt_next;
      batch_reg <= batch_next;
      epoch_reg <= epoch_next;
      valid_reg <= valid_next;
      if (started)
        started_r <= 1'b1;
      if (accept && !retire)
        outstanding_reg <= outstanding_reg + 8'd1;
      else if (!accept && retire && outstanding_reg != 8'd0)
        outstanding_reg <= outstanding_reg - 8'd1;
      if (hold)
        state_counters_sched <= state_counters_sched + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_addr_a_reg  <= 64'd0;
      cfg_addr_b_reg  <= 64'd0;
      cfg_batches_reg <= 32'd0;
      cfg_epochs_reg  <= 32'd0;
      cfg_a_lines_reg <= 16'd0;
    end else if (capture) begin
      cfg_addr_a_reg  <= addr_a;
      cfg_addr_b_reg  <= addr_b;
      cfg_batches_reg <= num_batches;
      cfg_epochs_reg  <= num_epochs;
      cfg_a_lines_reg <= a_lines_per_batch;
    end
  end

  assign rd.um_tx_rd_valid = valid_reg;
  assign rd.um_tx_rd_addr  = valid_reg ? ((state_reg == ISSUE_B) ? cur_b_reg : cur_a_reg) : 64'd0;
  assign rd.um_tx_rd_tag   = valid_reg ? ((state_reg == ISSUE_B) ? MEM_RD_B_TAG : MEM_RD_A_TAG) : 8'd0;
  assign sched_done        = (state_reg == DONE);

endmodule

// File: tb/tb_sgd_rd_scheduler.sv
// Randomized bench for sgd_rd_scheduler: expected request stream built from nested batch/epoch
// loops, plus protocol and counter checks against a small outstanding/stall model.
module tb_sgd_rd_scheduler;
  localparam int         MAX_OUT = 4;
  localparam logic [7:0] A_TAG   = 8'h0A;
  localparam logic [7:0] B_TAG   = 8'h0B;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  tag;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        started = 1'b0;
  logic [63:0] addr_a = 64'd0;
  logic [63:0] addr_b = 64'd0;
  logic [31:0] num_batches = 32'd0;
  logic [15:0] a_lines_per_batch = 16'd0;
  logic [31:0] num_epochs = 32'd0;
  logic        dispatch_almost_full = 1'b0;
  logic        sched_done;
  logic [31:0] state_counters_sched;

  sgd_rd_scheduler_if rd();

  sgd_rd_scheduler #(
    .MAX_OUTSTANDING(MAX_OUT),
    .LINE_BYTES     (64),
    .MEM_RD_A_TAG   (A_TAG),
    .MEM_RD_B_TAG   (B_TAG)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .started             (started),
    .addr_a              (addr_a),
    .addr_b              (addr_b),
    .num_batches         (num_batches),
    .a_lines_per_batch   (a_lines_per_batch),
    .num_epochs          (num_epochs),
    .rd                  (rd),
    .dispatch_almost_full(dispatch_almost_full),
    .sched_done          (sched_done),
    .state_counters_sched(state_counters_sched)
  );

  always #5 clk = ~clk;

  req_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned ready_pct = 100, resp_pct = 100, af_pct = 0;
  bit          start_req = 0, retire_once = 0;
  int          pend = 0, stall_model = 0, acc_cnt = 0, exp_total = 0;
  int          cyc = 0, start_cyc = 0, done_cyc = 0;
  bit          done_seen = 0, prev_valid = 0, prev_af = 0, prev_stall = 0;
  logic [63:0] prev_addr = 64'd0;
  logic [7:0]  prev_tag = 8'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive inputs just after the edge, observe at the falling edge; the observed values decide the next edge.
  task automatic step();
    bit   acc, ret, v;
    req_t e;
    @(posedge clk);
    #1;
    cyc++;
    rd.um_tx_rd_ready    = ($urandom_range(99) < ready_pct);
    dispatch_almost_full = ($urandom_range(99) < af_pct);
    if (retire_once) begin
      rd.um_rx_rd_valid = 1'b1;
      rd.um_rx_rd_ready = 1'b1;
      retire_once = 0;
    end else begin
      rd.um_rx_rd_valid = (pend > 0 || $urandom_range(9) == 0) && ($urandom_range(99) < resp_pct);
      rd.um_rx_rd_ready = ($urandom_range(3) != 0);
    end
    started = start_req;
    if (start_req) start_cyc = cyc;
    start_req = 0;
    @(negedge clk);
    v = rd.um_tx_rd_valid;
    if (prev_stall) begin
      check("hold_valid", 64'(v), 64'd1);
      check("hold_addr", rd.um_tx_rd_addr, prev_addr);
      check("hold_tag", 64'(rd.um_tx_rd_tag), 64'(prev_tag));
    end
    if (!prev_valid && prev_af) check("af_gate", 64'(v), 64'd0);
    if (sched_done) check("done_no_valid", 64'(v), 64'd0);
    if (sched_done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
      check("done_pend", 64'(pend), 64'd0);
      check("done_left", 64'(exp_q.size()), 64'd0);
    end
    acc = v && rd.um_tx_rd_ready;
    ret = rd.um_rx_rd_valid && rd.um_rx_rd_ready;
    if (acc) begin
      acc_cnt++;
      $display("[TB] req %0d addr=%h tag=%h", acc_cnt, rd.um_tx_rd_addr, rd.um_tx_rd_tag);
      if (exp_q.size() == 0) begin
        check("extra_req", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("req_addr", rd.um_tx_rd_addr, e.addr);
        check("req_tag", 64'(rd.um_tx_rd_tag), 64'(e.tag));
      end
    end
    if (acc && !ret) pend++;
    else if (!acc && ret && pend > 0) pend--;
    if (acc) check("outst_bound", 64'(pend <= MAX_OUT), 64'd1);
    if (v && !rd.um_tx_rd_ready) stall_model++;
    prev_valid = v;
    prev_af    = dispatch_almost_full;
    prev_stall = v && !rd.um_tx_rd_ready;
    prev_addr  = rd.um_tx_rd_addr;
    prev_tag   = rd.um_tx_rd_tag;
  endtask

  // Reset is asserted between clock edges so the outputs must clear without waiting for clk.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(rd.um_tx_rd_valid), 64'd0);
    check("rst_addr", rd.um_tx_rd_addr, 64'd0);
    check("rst_tag", 64'(rd.um_tx_rd_tag), 64'd0);
    check("rst_done", 64'(sched_done), 64'd0);
    check("rst_stall", 64'(state_counters_sched), 64'd0);
    started = 1'b0;
    start_req = 0;
    retire_once = 0;
    rd.um_tx_rd_ready = 1'b0;
    rd.um_rx_rd_valid = 1'b0;
    rd.um_rx_rd_ready = 1'b0;
    dispatch_almost_full = 1'b0;
    exp_q.delete();
    pend = 0; stall_model = 0; acc_cnt = 0; exp_total = 0;
    done_seen = 0; prev_valid = 0; prev_af = 0; prev_stall = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_job(input int al, input int nb, input int ne,
                           input logic [63:0] a, input logic [63:0] b);
    req_t r;
    do_reset();
    addr_a = a;
    addr_b = b;
    a_lines_per_batch = 16'(al);
    num_batches = 32'(nb);
    num_epochs = 32'(ne);
    exp_total = ne * nb * (al + 1);
    if (al == 0) exp_total = 0;
    for (int ep = 0; ep < ne; ep++) begin
      for (int bt = 0; bt < nb; bt++) begin
        for (int i = 0; i < al; i++) begin
          r.addr = a + 64'((longint'(bt) * al + i) * 64);
          r.tag  = A_TAG;
          exp_q.push_back(r);
        end
        r.addr = b + 64'(longint'(bt) * 64);
        r.tag  = B_TAG;
        exp_q.push_back(r);
      end
    end
    if (al == 0) exp_q.delete();
    start_req = 1;
    repeat (3) step();
    // Configuration has been captured; live inputs must no longer matter.
    addr_a = {$urandom, $urandom};
    addr_b = {$urandom, $urandom};
    num_batches = $urandom;
    num_epochs = $urandom;
    a_lines_per_batch = 16'($urandom);
  endtask

  task automatic finish_job(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) step();
    check("job_done", 64'(done_seen), 64'd1);
    check("job_left", 64'(exp_q.size()), 64'd0);
    check("job_total", 64'(acc_cnt), 64'(exp_total));
    check("job_stall", 64'(state_counters_sched), 64'(stall_model));
    start_req = 1;
    repeat (4) step();
    check("restart_ignored", 64'(sched_done), 64'd1);
  endtask

  initial begin
    logic [31:0] c0;
    logic [63:0] a, b;
    rd.um_tx_rd_ready = 1'b0;
    rd.um_rx_rd_valid = 1'b0;
    rd.um_rx_rd_ready = 1'b0;

    ready_pct = 100; resp_pct = 100; af_pct = 0;
    start_job(2, 2, 1, 64'h0000_0000_0001_0000, 64'h0000_0000_0008_0000);
    finish_job(200);

    start_job(1, 1, 2, 64'h0000_1234_0000_0040, 64'h0000_5678_0000_0000);
    finish_job(200);

    start_job(2, 0, 1, 64'h1000, 64'h2000);
    finish_job(50);
    check("zero_batch_latency", 64'((done_cyc - start_cyc) <= 3), 64'd1);
    start_job(0, 2, 1, 64'h1000, 64'h2000);
    finish_job(50);
    start_job(2, 2, 0, 64'h1000, 64'h2000);
    finish_job(50);

    ready_pct = 100; resp_pct = 0; af_pct = 0;
    start_job(8, 2, 1, 64'h4000, 64'h9000);
    repeat (20) step();
    check("max_out_acc", 64'(acc_cnt), 64'(MAX_OUT));
    check("max_out_valid", 64'(rd.um_tx_rd_valid), 64'd0);
    retire_once = 1;
    repeat (10) step();
    check("retire_one_acc", 64'(acc_cnt), 64'(MAX_OUT + 1));
    check("retire_one_valid", 64'(rd.um_tx_rd_valid), 64'd0);
    resp_pct = 100;
    finish_job(500);

    ready_pct = 0; resp_pct = 100; af_pct = 50;
    start_job(3, 2, 1, 64'h7000, 64'hA000);
    for (int i = 0; i < 20 && !rd.um_tx_rd_valid; i++) step();
    check("stall_valid_seen", 64'(rd.um_tx_rd_valid), 64'd1);
    c0 = state_counters_sched;
    repeat (10) step();
    check("stall_ten", 64'(state_counters_sched - c0), 64'd10);
    ready_pct = 100; af_pct = 0;
    finish_job(300);

    ready_pct = 100; resp_pct = 50; af_pct = 0;
    start_job(4, 2, 1, 64'hC000, 64'hE000);
    repeat (3) step();
    check("mid_run_accepts", 64'(acc_cnt > 0), 64'd1);
    do_reset();
    repeat (5) step();
    check("idle_no_valid", 64'(rd.um_tx_rd_valid), 64'd0);
    check("idle_no_done", 64'(sched_done), 64'd0);
    start_job(4, 2, 1, 64'hC000, 64'hE000);
    finish_job(500);

    for (int j = 0; j < 6; j++) begin
      ready_pct = $urandom_range(40, 100);
      resp_pct  = $urandom_range(30, 100);
      af_pct    = $urandom_range(0, 40);
      a = (j == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : ({$urandom, $urandom} & ~64'h3F);
      b = {$urandom, $urandom} & ~64'h3F;
      start_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 2)), a, b);
      finish_job(2000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
